// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a small first-word-fall-through FIFO.
//   rxd_i is double-flopped, deframed LSB-first by a five-state FSM and
//   queued. The FIFO head appears on data_o while valid_o is high, and
//   rd_i pops one byte per cycle.
// Ports:
//   clk_i, reset_i      clock, asynchronous active-high reset
//   rxd_i               serial input (idle high, asynchronous to clk_i)
//   rd_i                pop strobe
//   clr_err_i           clears sticky overrun_o / frame_err_o
//   data_o, valid_o     FIFO head byte and non-empty flag
//   count_o             FIFO occupancy
//   overrun_o           sticky: byte dropped because the FIFO was full
//   frame_err_o         sticky: stop bit sampled low
module uart_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        rxd_i,
  input  logic                        rd_i,
  input  logic                        clr_err_i,
  output logic [7:0]                  data_o,
  output logic                        valid_o,
  output logic [$clog2(FIFO_DEPTH):0] count_o,
  output logic                        overrun_o,
  output logic                        frame_err_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t        state_q, state_d;
  logic [1:0]    sync_q;
  logic          rxd;
  logic [CW-1:0] baud_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shreg_q;
  logic          shift_en, push, ferr_set;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic [7:0]    last_q;
  logic          full, pop, wr_en;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) sync_q <= '1;
    else         sync_q <= {sync_q[0], rxd_i};
  end
  assign rxd = sync_q[1];

  always_comb begin
    state_d  = state_q;
    shift_en = 1'b0;
    push     = 1'b0;
    ferr_set = 1'b0;
    unique case (state_q)
      S_IDLE:  if (!rxd) state_d = S_START;
      S_START: if (baud_q == HALF_LAST) state_d = rxd ? S_IDLE : S_DATA;
      S_DATA:  if (baud_q == BIT_LAST) begin
                 shift_en = 1'b1;
                 if (bit_idx_q == 3'd7) state_d = S_STOP;
               end
      S_STOP:  if (baud_q == BIT_LAST) begin
                 if (rxd) begin
                   push    = 1'b1;
                   state_d = S_IDLE;
                 end else begin
                   ferr_set = 1'b1;
                   state_d  = S_BREAK;
                 end
               end
      S_BREAK: if (rxd) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
    end else begin
      state_q <= state_d;
      // Counter restarts on every state change and wraps once per bit time.
      if (state_d != state_q || baud_q == BIT_LAST) baud_q <= '0;
      else                                          baud_q <= baud_q + CW'(1);
      if (state_q != S_DATA) bit_idx_q <= '0;
      else if (shift_en)     bit_idx_q <= bit_idx_q + 3'd1;
      if (shift_en) shreg_q <= {rxd, shreg_q[7:1]};
    end
  end

  assign full  = (count_q == FULL_CNT);
  assign pop   = rd_i && (count_q != '0);
  // When full, a same-cycle pop frees the head slot that wr_ptr points at.
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      last_q      <= '0;
      overrun_o   <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= shreg_q;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        last_q   <= mem_q[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (wr_en && !pop)      count_q <= count_q + (AW+1)'(1);
      else if (pop && !wr_en) count_q <= count_q - (AW+1)'(1);
      if (push && full && !pop) overrun_o <= 1'b1;
      else if (clr_err_i)       overrun_o <= 1'b0;
      if (ferr_set)        frame_err_o <= 1'b1;
      else if (clr_err_i)  frame_err_o <= 1'b0;
    end
  end

  // Empty FIFO keeps showing the most recently popped byte.
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : last_q;
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx (CLKS_PER_BIT=16,
// FIFO_DEPTH=4). Inputs change and outputs are sampled on the falling edge.
module tb_uart_rx;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rxd = 1'b1;
  logic       rd = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic [2:0] count;
  logic       overrun;
  logic       frame_err;

  int n_checks = 0;
  int n_fail   = 0;

  uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk_i(clk), .reset_i(reset), .rxd_i(rxd), .rd_i(rd), .clr_err_i(clr_err),
    .data_o(data), .valid_o(valid), .count_o(count),
    .overrun_o(overrun), .frame_err_o(frame_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called on a falling edge; leaves the line high after the stop bit.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      wait_cyc(CPB);
    end
    rxd = stop_bit;
    wait_cyc(CPB);
    rxd = 1'b1;
  endtask

  task automatic pop_one();
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic clear_err();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  initial begin
    wait_cyc(3);
    check_eq("rst_valid", valid, 0);
    check_eq("rst_count", count, 0);
    check_eq("rst_data", data, 0);
    check_eq("rst_ovr", overrun, 0);
    check_eq("rst_ferr", frame_err, 0);
    reset = 1'b0;
    wait_cyc(5);

    // 1: two back-to-back bytes, then drain
    send_byte(8'h55, 1'b1);
    send_byte(8'hA3, 1'b1);
    wait_cyc(4);
    check_eq("t1_count", count, 2);
    check_eq("t1_head0", data, 8'h55);
    pop_one();
    check_eq("t1_head1", data, 8'hA3);
    check_eq("t1_count1", count, 1);
    pop_one();
    check_eq("t1_valid", valid, 0);
    check_eq("t1_hold", data, 8'hA3);
    pop_one();
    check_eq("t1_underflow", count, 0);

    // 2: short glitch is rejected
    rxd = 1'b0;
    wait_cyc(4);
    rxd = 1'b1;
    wait_cyc(30);
    check_eq("t2_valid", valid, 0);
    check_eq("t2_ferr", frame_err, 0);
    check_eq("t2_ovr", overrun, 0);

    // 3: stop bit low -> frame error, byte discarded
    send_byte(8'h7E, 1'b0);
    wait_cyc(5);
    check_eq("t3_ferr", frame_err, 1);
    check_eq("t3_count", count, 0);
    clear_err();
    check_eq("t3_clr", frame_err, 0);

    // 4: overflow drops the fifth byte
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
    wait_cyc(4);
    check_eq("t4_count", count, 4);
    check_eq("t4_ovr", overrun, 1);
    for (int i = 1; i <= 4; i++) begin
      check_eq("t4_pop", data, i);
      pop_one();
    end
    check_eq("t4_empty", valid, 0);
    clear_err();
    check_eq("t4_ovr_clr", overrun, 0);

    // 4b: push into a full FIFO with a pop in the same cycle
    for (int i = 0; i < 4; i++) send_byte(8'h21 + 8'(i), 1'b1);
    check_eq("t4b_full", count, 4);
    fork
      send_byte(8'h25, 1'b1);
      begin
        // Stop-bit sample cycle: 2 sync + 1 idle + 8 start + 8*16 data + 15.
        wait_cyc(154);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
      end
    join
    wait_cyc(2);
    check_eq("t4b_count", count, 4);
    check_eq("t4b_ovr", overrun, 0);
    for (int i = 0; i < 4; i++) begin
      check_eq("t4b_pop", data, 8'h22 + 8'(i));
      pop_one();
    end
    check_eq("t4b_empty", count, 0);

    // 5: long break gives exactly one frame error
    rxd = 1'b0;
    wait_cyc(200);
    check_eq("t5_ferr", frame_err, 1);
    check_eq("t5_count", count, 0);
    clear_err();
    wait_cyc(30 * CPB - 201);
    check_eq("t5_no_repeat", frame_err, 0);
    rxd = 1'b1;
    wait_cyc(20);
    check_eq("t5_after", frame_err, 0);
    send_byte(8'h3C, 1'b1);
    wait_cyc(4);
    check_eq("t5_count1", count, 1);
    check_eq("t5_data", data, 8'h3C);
    check_eq("t5_ferr2", frame_err, 0);
    pop_one();

    // 6: reset during the data bits of 0xFF with two bytes queued
    send_byte(8'hA1, 1'b1);
    send_byte(8'hB2, 1'b1);
    check_eq("t6_queued", count, 2);
    rxd = 1'b0;
    wait_cyc(CPB);
    rxd = 1'b1;
    wait_cyc(4 * CPB);
    reset = 1'b1;
    #1;
    check_eq("t6_count", count, 0);
    check_eq("t6_valid", valid, 0);
    check_eq("t6_data", data, 0);
    check_eq("t6_flags", {overrun, frame_err}, 0);
    @(negedge clk);
    reset = 1'b0;
    wait_cyc(100);
    check_eq("t6_idle", count, 0);
    send_byte(8'h12, 1'b1);
    wait_cyc(4);
    check_eq("t6_count1", count, 1);
    check_eq("t6_data1", data, 8'h12);
    check_eq("t6_ferr", frame_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
